srl_fifo_ctrl: RTL
==================

Name: srl_fifo_ctrl

Overview:
- Control wrapper that sequences a shift-register (SRL) storage array as a first-word-fall-through FIFO.
- Generates the write-enable and read-address for the storage and exposes HLS-style full_n/empty_n handshakes.
- Also provides an occupancy count, an almost-full flag and sticky overflow/underflow error flags.
- Used for inter-PE start-token and data FIFOs in the Linear_Layer dataflow region; instantiates the shift-register storage internally.

Parameters:
- DATA_WIDTH, 1, payload width in bits.
- ADDR_WIDTH, 1, storage address width; DEPTH <= 2**ADDR_WIDTH.
- DEPTH, 2, number of entries; legal range 2..2**ADDR_WIDTH.
- AF_THRESH, DEPTH-1, occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- if_write_ce  in  1  write-side clock enable; a write counts only when this is 1.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  1 = space available.
- if_read_ce  in  1  read-side clock enable.
- if_read  in  1  read request (pop).
- if_dout  out  DATA_WIDTH  oldest entry; valid while if_empty_n = 1.
- if_empty_n  out  1  1 = data available.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- almost_full  out  1  1 when count >= AF_THRESH.
- overflow  out  1  sticky; set by a write attempt while full.
- underflow  out  1  sticky; set by a read attempt while empty.
- clear_err  in  1  clears overflow and underflow.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled on the clk rising edge.
- Qualified events:
  - wr = if_write_ce & if_write & if_full_n.
  - rd = if_read_ce & if_read & if_empty_n.
- Storage: DEPTH x DATA_WIDTH shift array.
  - On wr, every entry shifts up one position and entry 0 takes if_din.
  - if_dout = entry[ptr] combinationally (no output register).
- Pointer:
  - ptr (ADDR_WIDTH bits) = count-1 while count > 0; held at 0 while empty.
  - Update rules: wr & !rd -> ptr+1, except when count was 0, where ptr stays 0. rd & !wr -> ptr-1, except when count was 1, where ptr stays 0. wr & rd -> ptr unchanged.
- State machine (registered), states EMPTY, PARTIAL, FULL:
  - EMPTY: wr -> PARTIAL, or FULL if DEPTH==1 (not legal here). rd is impossible in EMPTY.
  - PARTIAL: wr & !rd with count==DEPTH-1 -> FULL. rd & !wr with count==1 -> EMPTY. Otherwise stay.
  - FULL: rd -> PARTIAL. wr is impossible in FULL.
- Output flags:
  - if_empty_n = (state != EMPTY).
  - if_full_n = (state != FULL).
  - Both are registered, derived from the state register; no combinational path from any request to any flag.
- Latency:
  - Data written at edge t is visible on if_dout, with if_empty_n=1, after edge t.
  - A pop at edge t frees space; if_full_n=1 after edge t.
  - Write and read on the same edge in FULL: the write is rejected, because full_n was 0.
- count:
  - +1 on wr only, -1 on rd only, unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- almost_full = (count >= AF_THRESH), registered alongside count.
- Error flags:
  - overflow is set when if_write_ce & if_write & !if_full_n.
  - underflow is set when if_read_ce & if_read & !if_empty_n.
  - Both are sticky until clear_err or reset.
  - clear_err and a new error on the same edge: the flag stays 1 (set wins).
- Reset, including reset asserted mid-operation:
  - state=EMPTY, ptr=0, count=0, if_empty_n=0, if_full_n=1, almost_full=0, overflow=0, underflow=0.
  - Storage contents are not reset, so if_dout is don't-care while empty.
  - Requests on the same edge as reset are ignored.
- CE gating: with the relevant *_ce=0, the request is ignored entirely, including for error detection.

Test Plan:
- Reset then idle, DEPTH=2 → if_empty_n=0, if_full_n=1, count=0, overflow=0, underflow=0.
- DEPTH=2: write 1 then write 0 on consecutive cycles → after the 2nd edge count=2, if_full_n=0, almost_full=1, if_dout=1. Pop → if_dout=0, count=1. Pop → if_empty_n=0.
- DEPTH=4, DATA_WIDTH=8: write 0x11, 0x22, 0x33, then simultaneous read+write of 0x44 for 3 cycles → count stays 3, if_dout sequence 0x11, 0x22, 0x33, then drains 0x44 last.
- Full DEPTH=2, assert read+write on the same edge → only the pop occurs: count=1, overflow=1, written data absent.
- Read while empty → underflow=1, count=0. Assert clear_err → underflow=0. Assert clear_err together with another empty read → underflow remains 1.
- DEPTH=4: fill to 3, assert reset for one cycle with write active → count=0, if_empty_n=1 never seen after reset, flags cleared; subsequent write of 0x5A appears on if_dout next cycle.

Source files
------------

// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: first-word-fall-through FIFO over a shift-register array.
// Registered full_n/empty_n, occupancy, almost-full and sticky error flags.
module srl_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2,
    parameter int AF_THRESH  = DEPTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_err
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    localparam logic [ADDR_WIDTH:0]   LP_C1  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   LP_DM1 = (ADDR_WIDTH+1)'(DEPTH-1);
    localparam logic [ADDR_WIDTH:0]   LP_AF  = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH-1:0] LP_P1  = ADDR_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  r_af;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_wr_err;
    logic                  w_rd_err;

    assign if_empty_n  = (r_state != S_EMPTY);
    assign if_full_n   = (r_state != S_FULL);
    assign count       = r_count;
    assign almost_full = r_af;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;

    assign w_wr     = if_write_ce & if_write & if_full_n;
    assign w_rd     = if_read_ce & if_read & if_empty_n;
    assign w_wr_err = if_write_ce & if_write & ~if_full_n;
    assign w_rd_err = if_read_ce & if_read & ~if_empty_n;

    // Shift array: new word enters at entry 0, older words move up.
    always_ff @(posedge clk) begin
        if (!reset && w_wr) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
            r_mem[0] <= if_din;
        end
    end

    // Read mux: the oldest word sits at entry ptr.
    always_comb begin
        if_dout = r_mem[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (r_ptr == ADDR_WIDTH'(i)) begin
                if_dout = r_mem[i];
            end
        end
    end

    // Next occupancy, shared by count and almost_full.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd) begin
            w_count_nxt = r_count + LP_C1;
        end else if (w_rd && !w_wr) begin
            w_count_nxt = r_count - LP_C1;
        end
    end

    // Pointer tracks count-1, pinned at 0 across empty/one-entry edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_wr && !w_rd) begin
            if (r_count != '0) begin
                r_ptr <= r_ptr + LP_P1;
            end
        end else if (w_rd && !w_wr) begin
            if (r_count == LP_C1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_ptr - LP_P1;
            end
        end
    end

    // Occupancy and almost-full registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_af    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_af    <= (w_count_nxt >= LP_AF);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for EMPTY/PARTIAL/FULL.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: begin
                if (w_wr) begin
                    w_state_nxt = S_PARTIAL;
                end
            end
            S_PARTIAL: begin
                if (w_wr && !w_rd && r_count == LP_DM1) begin
                    w_state_nxt = S_FULL;
                end else if (w_rd && !w_wr && r_count == LP_C1) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_rd) begin
                    w_state_nxt = S_PARTIAL;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // Sticky error flags; a new error beats clear_err on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_wr_err) begin
                r_ovf <= 1'b1;
            end else if (clear_err) begin
                r_ovf <= 1'b0;
            end
            if (w_rd_err) begin
                r_udf <= 1'b1;
            end else if (clear_err) begin
                r_udf <= 1'b0;
            end
        end
    end

endmodule
